// File: rtl/pipelined_rc_adder.sv
// Pipelined ripple-carry adder/subtractor: CHUNK bits are added per stage, the carry is
// registered between stages, and a valid/ready handshake with a global advance controls flow.
module pipelined_rc_adder #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CHUNK = WIDTH / STAGES;
  localparam int unsigned LAST  = STAGES - 1;

  logic             vld [STAGES];
  logic             cy  [STAGES];
  logic [WIDTH-1:0] opa [STAGES];
  logic [WIDTH-1:0] opb [STAGES];
  logic [WIDTH-1:0] acc [STAGES];

  logic             src_v   [STAGES];
  logic             src_c   [STAGES];
  logic [WIDTH-1:0] src_a   [STAGES];
  logic [WIDTH-1:0] src_b   [STAGES];
  logic [WIDTH-1:0] src_acc [STAGES];
  logic [CHUNK:0]   part    [STAGES];
  logic [WIDTH-1:0] nxt_acc [STAGES];

  logic adv;

  function automatic logic [CHUNK:0] ripple(input logic [CHUNK-1:0] x,
                                            input logic [CHUNK-1:0] y,
                                            input logic             ci);
    logic [CHUNK-1:0] s;
    logic             c;
    s = '0;
    c = ci;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return {c, s};
  endfunction

  assign adv       = out_ready | ~out_valid;
  assign in_ready  = adv;
  assign out_valid = vld[LAST];
  assign sum       = acc[LAST];
  assign cout      = cy[LAST];
  assign ovf       = (opa[LAST][WIDTH-1] == opb[LAST][WIDTH-1]) &
                     (acc[LAST][WIDTH-1] != opa[LAST][WIDTH-1]);

  // Stage 0 works on the live inputs with B and carry-in already inverted for subtract;
  // later stages work on the previous stage's registers.
  always_comb begin
    src_v[0]   = in_valid;
    src_a[0]   = a;
    src_b[0]   = sub ? ~b : b;
    src_c[0]   = cin ^ sub;
    src_acc[0] = '0;
    for (int unsigned k = 1; k < STAGES; k++) begin
      src_v[k]   = vld[k-1];
      src_a[k]   = opa[k-1];
      src_b[k]   = opb[k-1];
      src_c[k]   = cy[k-1];
      src_acc[k] = acc[k-1];
    end
    for (int unsigned k = 0; k < STAGES; k++) begin
      part[k]    = ripple(src_a[k][k*CHUNK +: CHUNK], src_b[k][k*CHUNK +: CHUNK], src_c[k]);
      nxt_acc[k] = src_acc[k];
      nxt_acc[k][k*CHUNK +: CHUNK] = part[k][CHUNK-1:0];
    end
  end

  // Data moves only with a valid token, so outputs keep the last result across bubbles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        vld[k] <= 1'b0;
        cy[k]  <= 1'b0;
        opa[k] <= '0;
        opb[k] <= '0;
        acc[k] <= '0;
      end
    end else if (adv) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        vld[k] <= src_v[k];
        if (src_v[k]) begin
          opa[k] <= src_a[k];
          opb[k] <= src_b[k];
          cy[k]  <= part[k][CHUNK];
          acc[k] <= nxt_acc[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_rc_adder.sv
// Bench for pipelined_rc_adder: one 16-bit/4-stage instance plus 4-bit instances with 1, 2, 4
// stages, checked against an integer-arithmetic model through in-order expectation queues.
module tb_pipelined_rc_adder;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  logic clk;
  logic rst_n;

  logic        in_valid16, in_ready16, out_valid16, out_ready16;
  logic [15:0] a16, b16, sum16;
  logic        cin16, sub16, cout16, ovf16;

  logic        in_valid4, out_ready4;
  logic [3:0]  a4, b4;
  logic        cin4, sub4;
  logic        in_ready4 [3];
  logic        out_valid4 [3];
  logic [3:0]  sum4 [3];
  logic        cout4 [3];
  logic        ovf4 [3];

  int checks = 0;
  int errors = 0;

  logic [17:0] q16[$];
  logic [17:0] exp4 [2048];
  int          wr4 = 0;
  int          rd4 [3];
  int          stg4 [3];

  logic        last_acc16;
  logic        ov16_pre, ir16_pre;
  logic [17:0] res16_pre;
  logic        ov4_pre [3];
  logic        prev_stall = 1'b0;
  logic [17:0] prev_res;

  pipelined_rc_adder #(.WIDTH(16), .STAGES(4)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .cin(cin16), .sub(sub16), .out_valid(out_valid16),
    .out_ready(out_ready16), .sum(sum16), .cout(cout16), .ovf(ovf16));

  pipelined_rc_adder #(.WIDTH(4), .STAGES(1)) u4s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4[0]),
    .a(a4), .b(b4), .cin(cin4), .sub(sub4), .out_valid(out_valid4[0]),
    .out_ready(out_ready4), .sum(sum4[0]), .cout(cout4[0]), .ovf(ovf4[0]));

  pipelined_rc_adder #(.WIDTH(4), .STAGES(2)) u4s2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4[1]),
    .a(a4), .b(b4), .cin(cin4), .sub(sub4), .out_valid(out_valid4[1]),
    .out_ready(out_ready4), .sum(sum4[1]), .cout(cout4[1]), .ovf(ovf4[1]));

  pipelined_rc_adder #(.WIDTH(4), .STAGES(4)) u4s4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4[2]),
    .a(a4), .b(b4), .cin(cin4), .sub(sub4), .out_valid(out_valid4[2]),
    .out_ready(out_ready4), .sum(sum4[2]), .cout(cout4[2]), .ovf(ovf4[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: exact integer result; carry from range of the unsigned result, overflow from
  // range of the signed result. Packed as {cout, ovf, sum[15:0]}.
  function automatic logic [17:0] ref_add(int w, int x, int y, int c, int s);
    int r, sx, sy, sr, full, half;
    logic [15:0] res;
    logic co, ov;
    full = 1 << w;
    half = 1 << (w - 1);
    r    = s ? x - y - c : x + y + c;
    res  = 16'(r & (full - 1));
    co   = s ? (r >= 0) : (r >= full);
    sx   = (x >= half) ? x - full : x;
    sy   = (y >= half) ? y - full : y;
    sr   = s ? sx - sy - c : sx + sy + c;
    ov   = (sr < -half) || (sr > half - 1);
    return {co, ov, res};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  // One clock: settle, sample/score before the edge, advance, then step off the edge.
  task automatic tick();
    logic [17:0] cur;
    #1;
    cur = {cout16, ovf16, sum16};
    if (rst_n && prev_stall) chk("hold16", cur, prev_res);
    prev_stall = rst_n && out_valid16 && !out_ready16;
    prev_res   = cur;
    ov16_pre   = out_valid16;
    ir16_pre   = in_ready16;
    res16_pre  = cur;
    last_acc16 = rst_n && in_valid16 && in_ready16;
    if (rst_n && out_valid16 && out_ready16) begin
      chk("q16_nonempty", q16.size() > 0, 1);
      if (q16.size() > 0) chk("result16", cur, q16.pop_front());
    end
    if (last_acc16) q16.push_back(ref_add(16, int'(a16), int'(b16), int'(cin16), int'(sub16)));
    for (int d = 0; d < 3; d++) begin
      ov4_pre[d] = out_valid4[d];
      if (rst_n && out_valid4[d] && out_ready4) begin
        chk("q4_nonempty", rd4[d] < wr4, 1);
        if (rd4[d] < wr4) begin
          chk("result4", {cout4[d], ovf4[d], 12'h000, sum4[d]}, exp4[rd4[d] % 2048]);
          rd4[d]++;
        end
      end
      if (rst_n && in_valid4) chk("in_ready4", in_ready4[d], 1);
    end
    if (rst_n && in_valid4) begin
      exp4[wr4 % 2048] = ref_add(4, int'(a4), int'(b4), int'(cin4), int'(sub4));
      wr4++;
    end
    @(posedge clk);
    if (!rst_n) begin
      q16.delete();
      for (int d = 0; d < 3; d++) rd4[d] = wr4;
    end
    #1;
  endtask

  vec_t        tbl [8];
  logic        pat [20];
  logic [15:0] sa [8];
  logic [15:0] sb [8];
  logic        sc [8];
  logic        ss [8];
  logic [17:0] hold;
  int          j, t;

  initial begin
    stg4[0] = 1; stg4[1] = 2; stg4[2] = 4;
    for (int d = 0; d < 3; d++) rd4[d] = 0;
    tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tbl[4] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
    tbl[5] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    tbl[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[7] = '{16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};

    rst_n = 1'b0;
    in_valid16 = 1'b1; out_ready16 = 1'b1; a16 = 16'h1111; b16 = 16'h2222; cin16 = 1'b0; sub16 = 1'b0;
    in_valid4 = 1'b0; out_ready4 = 1'b1; a4 = '0; b4 = '0; cin4 = 1'b0; sub4 = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    in_valid16 = 1'b0;
    #1;
    chk("reset_out_valid", out_valid16, 0);
    chk("reset_result", {cout16, ovf16, sum16}, 0);
    chk("reset_in_ready", in_ready16, 1);

    // Directed vectors: exact latency, table values, inputs scrambled while in flight.
    for (int i = 0; i < 8; i++) begin
      a16 = tbl[i].a; b16 = tbl[i].b; cin16 = tbl[i].cin; sub16 = tbl[i].sub;
      in_valid16 = 1'b1;
      tick();
      in_valid16 = 1'b0;
      for (int k = 0; k < 6; k++) begin
        chk("latency_valid", out_valid16, (k == 3) ? 1 : 0);
        if (k == 3) chk("table_result", {cout16, ovf16, sum16}, {tbl[i].cout, tbl[i].ovf, tbl[i].sum});
        a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom); sub16 = 1'($urandom);
        tick();
      end
    end

    // Alternating valid pattern reappears delayed by each instance's stage count.
    for (int i = 0; i < 20; i++) begin
      pat[i] = (i % 2 == 0);
      in_valid16 = pat[i]; in_valid4 = pat[i];
      a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom); sub16 = 1'($urandom);
      a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom); sub4 = 1'($urandom);
      tick();
      chk("alt_valid16", ov16_pre, (i >= 4) ? pat[i-4] : 1'b0);
      for (int d = 0; d < 3; d++)
        chk("alt_valid4", ov4_pre[d], (i >= stg4[d]) ? pat[i-stg4[d]] : 1'b0);
    end
    in_valid16 = 1'b0; in_valid4 = 1'b0;
    repeat (6) tick();

    // Eight back-to-back operations with a three-cycle downstream stall.
    for (int i = 0; i < 8; i++) begin
      sa[i] = 16'($urandom); sb[i] = 16'($urandom); sc[i] = 1'($urandom); ss[i] = 1'($urandom);
    end
    j = 0; t = 0; hold = '0;
    while ((j < 8 || q16.size() > 0) && t < 40) begin
      in_valid16 = (j < 8);
      if (j < 8) begin a16 = sa[j]; b16 = sb[j]; cin16 = sc[j]; sub16 = ss[j]; end
      out_ready16 = !(t >= 5 && t <= 7);
      tick();
      if (t >= 5 && t <= 7) begin
        chk("stall_in_ready", ir16_pre, 0);
        chk("stall_out_valid", ov16_pre, 1);
        if (t == 5) hold = res16_pre;
        else chk("stall_hold", res16_pre, hold);
      end
      if (last_acc16) j++;
      t++;
    end
    chk("stream_accepted", j, 8);
    chk("stream_drained", q16.size(), 0);
    in_valid16 = 1'b0; out_ready16 = 1'b1;

    // Reset with three operations in flight: none of them may ever come out.
    for (int i = 0; i < 3; i++) begin
      a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom); sub16 = 1'($urandom);
      in_valid16 = 1'b1;
      tick();
    end
    rst_n = 1'b0;
    a16 = 16'hABCD; b16 = 16'h1234;
    tick();
    rst_n = 1'b1; in_valid16 = 1'b0;
    chk("midreset_out_valid", out_valid16, 0);
    chk("midreset_result", {cout16, ovf16, sum16}, 0);
    chk("midreset_in_ready", in_ready16, 1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("midreset_no_stale", ov16_pre, 0);
    end

    // Random traffic with random backpressure.
    for (int i = 0; i < 300; i++) begin
      in_valid16  = ($urandom_range(0, 3) != 0);
      out_ready16 = ($urandom_range(0, 3) != 0);
      a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom); sub16 = 1'($urandom);
      tick();
    end
    in_valid16 = 1'b0; out_ready16 = 1'b1;
    for (int i = 0; i < 20 && q16.size() > 0; i++) tick();
    chk("random_drained", q16.size(), 0);

    // Exhaustive 4-bit sweep over a, b, cin and both modes.
    for (int i = 0; i < 1024; i++) begin
      a4 = 4'(i); b4 = 4'(i >> 4); cin4 = 1'(i >> 8); sub4 = 1'(i >> 9);
      in_valid4 = 1'b1;
      tick();
    end
    in_valid4 = 1'b0;
    repeat (6) tick();
    for (int d = 0; d < 3; d++) chk("sweep4_all_results", rd4[d], wr4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
